gf_mul_arbiter: RTL and testbench
=================================

Name: gf_mul_arbiter

Overview:
- Shares one pipelined 32-bit prime-field multiplier (modulus P = 32'hec940e71, i_start/o_done interface, fixed latency) among N_REQ requesters.
- Round-robin arbiter selects at most one issue per cycle and registers the operands into the multiplier.
- An in-order ID tag FIFO routes each result back to the requester that issued it.
- Sits between the signing-round polynomial engines and the shared multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester-ID width; must equal clog2(N_REQ)
- DATA_W, 32, operand and result width
- TAG_DEPTH, 16, maximum outstanding operations; must be ≥ multiplier latency

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  N_REQ  per-requester request; operands valid while high
- i_x  in  N_REQ*DATA_W  packed operand x, requester k at [k*DATA_W +: DATA_W]
- i_y  in  N_REQ*DATA_W  packed operand y, same packing as i_x
- o_gnt  out  N_REQ  combinational one-hot grant; a handshake occurs on a clock edge where i_req[k] and o_gnt[k] are both high
- o_mul_start  out  1  issue pulse to the multiplier
- o_mul_x  out  DATA_W  registered operand x
- o_mul_y  out  DATA_W  registered operand y
- i_mul_done  in  1  multiplier result valid
- i_mul_o  in  DATA_W  multiplier result
- o_res_valid  out  1  result pulse to requesters
- o_res_id  out  ID_W  index of the requester that owns o_res
- o_res  out  DATA_W  result data
- o_busy  out  1  high while outstanding count > 0
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (async, i_rst_n low): clear all registers immediately.
  - o_mul_start, o_res_valid, o_busy and o_err go to 0.
  - o_mul_x, o_mul_y, o_res and o_res_id go to 0.
  - RR pointer, outstanding count and FIFO read/write pointers go to 0.
  - o_gnt = 0 during reset.
- Reset mid-operation discards in-flight tags. Any i_mul_done arriving afterwards sets o_err.
- Arbitration:
  - Search starts at the RR pointer and grants the first index k with i_req[k] high.
  - o_gnt = 0 when no request is pending or count == TAG_DEPTH (full).
  - After a handshake, pointer ← (k+1) mod N_REQ. With no handshake, the pointer holds.
  - A single continuously requesting master is granted every cycle (100% throughput).
  - All masters requesting gives strict rotation.
- Issue (cycle after a handshake):
  - o_mul_start = 1 for exactly one cycle.
  - o_mul_x and o_mul_y hold the granted operands; they stay held (not cleared) when no issue occurs.
  - The tag FIFO pushes k on the handshake edge.
- Return:
  - On i_mul_done, pop the FIFO head.
  - Next cycle: o_res_valid = 1, o_res_id = popped ID, o_res = registered i_mul_o.
  - Results are in issue order. Requesters must accept them; there is no backpressure.
- Outstanding count:
  - +1 on handshake, −1 on i_mul_done, unchanged when both occur in the same cycle.
  - o_busy = (count != 0), registered.
- Full: at count == TAG_DEPTH, grants are suppressed. If a pop occurs in the same cycle, the grant is still suppressed and resumes the next cycle.
- FIFO pointers: wrap modulo TAG_DEPTH. TAG_DEPTH is a power of two.
- Error: i_mul_done with count == 0 sets o_err. In that case there is no pop, no o_res_valid, and count stays 0. o_err clears only on reset.
- Operand width: the block does not reduce operands. Requesters supply values < P.

Test Plan:
(All scenarios use a stub multiplier of latency 12 that returns x*y mod P.)
- Single op: req0 with x=2, y=3 → o_gnt=4'b0001 same cycle; o_mul_start next cycle; o_res_valid 13 cycles after issue with o_res=6, o_res_id=0; o_busy 1→0.
- Negative-one square: req2 with x=y=32'hec940e70 → o_res=1, o_res_id=2.
- Fairness: all four requests held high for 8 cycles → grant order 0,1,2,3,0,1,2,3; results return in the same ID order with correct products.
- Full stall: TAG_DEPTH=4, req1 held high → exactly 4 grants, then o_gnt=0 until the first i_mul_done; the next grant comes the following cycle; count never exceeds 4.
- Simultaneous push/pop: steady stream from req3 at one grant per cycle → count constant at 13 in steady state; every result has o_res_id=3.
- Reset and error: assert i_rst_n low with 5 ops in flight → all outputs 0 asynchronously; the stub's late i_mul_done pulses set o_err=1 with no o_res_valid.

Source files
------------

// File: rtl/gf_mul_arbiter.sv
// rtl/gf_mul_arbiter.sv - round-robin sharing of one pipelined prime-field multiplier
// Results are routed back to their requester through an in-order ID tag FIFO.
module gf_mul_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ID_W      = 2,
   parameter int DATA_W    = 32,
   parameter int TAG_DEPTH = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*DATA_W-1:0] i_x,
   input  logic [N_REQ*DATA_W-1:0] i_y,
   output logic [N_REQ-1:0]        o_gnt,
   output logic                    o_mul_start,
   output logic [DATA_W-1:0]       o_mul_x,
   output logic [DATA_W-1:0]       o_mul_y,
   input  logic                    i_mul_done,
   input  logic [DATA_W-1:0]       i_mul_o,
   output logic                    o_res_valid,
   output logic [ID_W-1:0]         o_res_id,
   output logic [DATA_W-1:0]       o_res,
   output logic                    o_busy,
   output logic                    o_err
);
   localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

   logic [ID_W-1:0]   r_rr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [ID_W-1:0]   r_tag [TAG_DEPTH];
   logic              r_mul_start;
   logic [DATA_W-1:0] r_mul_x;
   logic [DATA_W-1:0] r_mul_y;
   logic              r_res_valid;
   logic [ID_W-1:0]   r_res_id;
   logic [DATA_W-1:0] r_res;
   logic              r_busy;
   logic              r_err;

   logic              w_found;
   logic [ID_W-1:0]   w_gnt_idx;
   logic [DATA_W-1:0] w_sel_x;
   logic [DATA_W-1:0] w_sel_y;
   logic [N_REQ-1:0]  w_gnt;
   logic              w_full;
   logic              w_hs;
   logic              w_pop;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [ID_W-1:0]   w_ptr_nxt;

   // Pass 0 scans indices at/after the pointer, pass 1 wraps to those before it.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_sel_x   = '0;
      w_sel_y   = '0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && i_req[k] && ((p == 0) == (k >= int'(r_rr_ptr)))) begin
               w_found   = 1'b1;
               w_gnt_idx = ID_W'(k);
               w_sel_x   = i_x[k*DATA_W +: DATA_W];
               w_sel_y   = i_y[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign w_full = (r_count == FULL_CNT);

   always_comb begin
      w_gnt = '0;
      if (w_found && !w_full && i_rst_n)
         w_gnt[w_gnt_idx] = 1'b1;
   end

   assign w_hs      = |w_gnt;
   assign w_pop     = i_mul_done && (r_count != '0);
   assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_hs, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr    <= '0;
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_mul_start <= 1'b0;
         r_mul_x     <= '0;
         r_mul_y     <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res       <= '0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mul_start <= w_hs;
         if (w_hs) begin
            r_rr_ptr <= w_ptr_nxt;
            r_mul_x  <= w_sel_x;
            r_mul_y  <= w_sel_y;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         r_res_valid <= w_pop;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_res_id <= r_tag[r_rd_ptr];
            r_res    <= i_mul_o;
         end
         r_count <= w_count_nxt;
         r_busy  <= (w_count_nxt != '0);
         // A result with nothing outstanding means the tag stream is out of sync.
         if (i_mul_done && (r_count == '0))
            r_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_hs)
         r_tag[r_wr_ptr] <= w_gnt_idx;
   end

   assign o_gnt       = w_gnt;
   assign o_mul_start = r_mul_start;
   assign o_mul_x     = r_mul_x;
   assign o_mul_y     = r_mul_y;
   assign o_res_valid = r_res_valid;
   assign o_res_id    = r_res_id;
   assign o_res       = r_res;
   assign o_busy      = r_busy;
   assign o_err       = r_err;
endmodule

// File: tb/tb_gf_mul_arbiter.sv
// tb/tb_gf_mul_arbiter.sv - directed scoreboard bench for gf_mul_arbiter
// Two instances: default depth 16, and depth 4 for the full-stall case.
module tb_gf_mul_arbiter;
   localparam int LAT = 12;
   localparam logic [31:0] P = 32'hec940e71;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [3:0]   req_a, req_b;
   logic [127:0] x_a, y_a, x_b, y_b;
   logic [3:0]   gnt_a, gnt_b;
   logic         start_a, start_b;
   logic [31:0]  mx_a, my_a, mx_b, my_b;
   logic         done_a, done_b;
   logic [31:0]  mo_a, mo_b;
   logic         rv_a, rv_b;
   logic [1:0]   rid_a, rid_b;
   logic [31:0]  res_a, res_b;
   logic         busy_a, busy_b;
   logic         err_a, err_b;

   gf_mul_arbiter u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_x(x_a), .i_y(y_a),
      .o_gnt(gnt_a), .o_mul_start(start_a), .o_mul_x(mx_a), .o_mul_y(my_a),
      .i_mul_done(done_a), .i_mul_o(mo_a), .o_res_valid(rv_a), .o_res_id(rid_a),
      .o_res(res_a), .o_busy(busy_a), .o_err(err_a));

   gf_mul_arbiter #(.TAG_DEPTH(4)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_x(x_b), .i_y(y_b),
      .o_gnt(gnt_b), .o_mul_start(start_b), .o_mul_x(mx_b), .o_mul_y(my_b),
      .i_mul_done(done_b), .i_mul_o(mo_b), .o_res_valid(rv_b), .o_res_id(rid_b),
      .o_res(res_b), .o_busy(busy_b), .o_err(err_b));

   int checks = 0;
   int errors = 0;
   int res_cnt_b = 0;

   typedef struct packed { logic [1:0] id; logic [31:0] val; } sb_t;
   sb_t sb_q[$];

   function automatic logic [31:0] mulmod(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] t;
      t = {32'b0, a} * {32'b0, b};
      return 32'(t % {32'b0, P});
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stub multipliers of fixed latency; not reset so late results survive a DUT reset.
   logic        sv_a [LAT];
   logic [31:0] sd_a [LAT];
   logic        sv_b [LAT];
   logic [31:0] sd_b [LAT];
   always @(posedge clk) begin
      sv_a[0] <= start_a;
      sd_a[0] <= mulmod(mx_a, my_a);
      sv_b[0] <= start_b;
      sd_b[0] <= mulmod(mx_b, my_b);
      for (int i = 1; i < LAT; i++) begin
         sv_a[i] <= sv_a[i-1];
         sd_a[i] <= sd_a[i-1];
         sv_b[i] <= sv_b[i-1];
         sd_b[i] <= sd_b[i-1];
      end
   end
   assign done_a = sv_a[LAT-1];
   assign mo_a   = sd_a[LAT-1];
   assign done_b = sv_b[LAT-1];
   assign mo_b   = sd_b[LAT-1];

   always @(negedge clk) begin
      if (rv_a) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_res", {63'b0, rv_a}, 64'd0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("sb_res_id", {62'b0, rid_a}, {62'b0, e.id});
            chk("sb_res_val", {32'b0, res_a}, {32'b0, e.val});
         end
      end
      if (rst_n) begin
         for (int k = 0; k < 4; k++)
            if (req_a[k] && gnt_a[k])
               sb_q.push_back({2'(k), mulmod(x_a[k*32 +: 32], y_a[k*32 +: 32])});
      end
      if (rv_b) begin
         chk("res_b_val", {32'b0, res_b}, 64'd15);
         chk("res_b_id", {62'b0, rid_b}, 64'd1);
         res_cnt_b++;
      end
   end

   task automatic single_op(input int k, input logic [31:0] xv, input logic [31:0] yv,
                            input logic [31:0] exp);
      int cyc;
      @(posedge clk); #1;
      req_a = 4'(1 << k);
      x_a[k*32 +: 32] = xv;
      y_a[k*32 +: 32] = yv;
      @(negedge clk);
      chk("op_gnt", {60'b0, gnt_a}, 64'(1 << k));
      @(posedge clk); #1;
      req_a = 4'b0;
      @(negedge clk);
      chk("op_start", {63'b0, start_a}, 64'd1);
      chk("op_mul_x", {32'b0, mx_a}, {32'b0, xv});
      chk("op_mul_y", {32'b0, my_a}, {32'b0, yv});
      chk("op_busy_hi", {63'b0, busy_a}, 64'd1);
      @(negedge clk);
      chk("op_start_pulse", {63'b0, start_a}, 64'd0);
      chk("op_mul_x_held", {32'b0, mx_a}, {32'b0, xv});
      cyc = 1;
      while (!rv_a && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("op_latency", 64'(cyc), 64'd13);
      chk("op_res", {32'b0, res_a}, {32'b0, exp});
      chk("op_res_id", {62'b0, rid_a}, 64'(k));
      chk("op_busy_lo", {63'b0, busy_a}, 64'd0);
   endtask

   task automatic drain(input string tag);
      int cyc;
      cyc = 0;
      while ((busy_a || busy_b) && cyc < 80) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      chk(tag, {63'b0, busy_a | busy_b}, 64'd0);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int rv_seen;
      for (int i = 0; i < LAT; i++) begin
         sv_a[i] = 1'b0; sd_a[i] = '0; sv_b[i] = 1'b0; sd_b[i] = '0;
      end
      rst_n = 1'b0;
      req_a = 4'b1111;
      req_b = 4'b0;
      x_a = '0; y_a = '0; x_b = '0; y_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", {60'b0, gnt_a}, 64'd0);
      chk("rst_start", {63'b0, start_a}, 64'd0);
      chk("rst_res_valid", {63'b0, rv_a}, 64'd0);
      chk("rst_busy", {63'b0, busy_a}, 64'd0);
      chk("rst_err", {63'b0, err_a}, 64'd0);
      chk("rst_mul_x", {32'b0, mx_a}, 64'd0);
      chk("rst_res", {32'b0, res_a}, 64'd0);
      @(posedge clk); #1;
      req_a = 4'b0;
      rst_n = 1'b1;

      single_op(0, 32'd2, 32'd3, 32'd6);
      single_op(2, 32'hec940e70, 32'hec940e70, 32'd1);
      single_op(3, 32'd5, 32'd7, 32'd35);

      // Fairness: pointer is back at 0, all four requesting.
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         x_a[k*32 +: 32] = 32'hdead0000 + 32'(k);
         y_a[k*32 +: 32] = 32'h0badf00d * 32'(k + 1);
      end
      req_a = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("fair_gnt", {60'b0, gnt_a}, 64'(1 << (i % 4)));
      end
      @(posedge clk); #1;
      req_a = 4'b0;
      drain("fair_drain");

      // Full stall on the depth-4 instance.
      @(posedge clk); #1;
      x_b[63:32] = 32'd3;
      y_b[63:32] = 32'd5;
      req_b = 4'b0010;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         chk("full_gnt", {60'b0, gnt_b}, (i < 4 || i >= 14) ? 64'd2 : 64'd0);
         chk("full_cnt_max", {63'b0, u_dut4.r_count <= 3'd4}, 64'd1);
      end
      @(posedge clk); #1;
      req_b = 4'b0;
      drain("full_drain");
      chk("full_res_cnt", 64'(res_cnt_b), 64'd7);

      // Steady stream from requester 3.
      @(posedge clk); #1;
      x_a[127:96] = 32'h12345678;
      y_a[127:96] = 32'h9abcdef0;
      req_a = 4'b1000;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("stream_gnt", {60'b0, gnt_a}, 64'd8);
         chk("stream_cnt", {59'b0, u_dut.r_count}, (i < 13) ? 64'(i) : 64'd13);
      end
      @(posedge clk); #1;
      req_a = 4'b0;
      drain("stream_drain");

      // Reset with five operations in flight.
      @(posedge clk); #1;
      x_a[31:0] = 32'd7;
      y_a[31:0] = 32'd9;
      req_a = 4'b0001;
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      req_a = 4'b0;
      @(negedge clk);
      @(posedge clk); #3;
      rst_n = 1'b0;
      req_a = 4'b0001;
      #1;
      chk("arst_gnt", {60'b0, gnt_a}, 64'd0);
      chk("arst_start", {63'b0, start_a}, 64'd0);
      chk("arst_busy", {63'b0, busy_a}, 64'd0);
      chk("arst_mul_x", {32'b0, mx_a}, 64'd0);
      chk("arst_mul_y", {32'b0, my_a}, 64'd0);
      chk("arst_res", {32'b0, res_a}, 64'd0);
      chk("arst_res_id", {62'b0, rid_a}, 64'd0);
      chk("arst_res_valid", {63'b0, rv_a}, 64'd0);
      chk("arst_err", {63'b0, err_a}, 64'd0);
      req_a = 4'b0;
      sb_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      rv_seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (rv_a) rv_seen++;
      end
      chk("late_err", {63'b0, err_a}, 64'd1);
      chk("late_no_res", 64'(rv_seen), 64'd0);
      chk("late_busy", {63'b0, busy_a}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
